// File: rtl/uart_tx_driver.sv
// ============================================================================
// Module   : uart_tx_driver
// Purpose  : FIFO-buffered UART transmitter that injects console characters
//            onto the SoC io_uart_rx pin as fixed-rate serial frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_driver #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          STX,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   tx_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLK_DIV);

    localparam logic [BAUD_W-1:0] c_BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [PTR_W:0]    c_FULL_LEVEL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [2:0]        c_LAST_BIT    = 3'(DATA_BITS - 1);
    localparam logic              c_LAST_STOP   = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_level;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_cnt;
    logic              r_stop_cnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [31:0]       r_tx_count;
    logic              r_stx_unused;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_bit_end;
    logic w_frame_done;
    logic w_par_bit;

    assign w_full       = (r_level == c_FULL_LEVEL);
    assign w_empty      = (r_level == '0);
    assign w_push       = in_valid && !w_full;
    assign w_bit_end    = (r_baud == '0);
    assign w_frame_done = (r_state == S_STOP) && w_bit_end && (r_stop_cnt == c_LAST_STOP);
    // A new frame is fetched either from idle or seamlessly at the end of the last stop bit.
    assign w_pop        = !w_empty && ((r_state == S_IDLE) || w_frame_done);
    assign w_par_bit    = (PARITY == 1) ? ~r_parity : r_parity;

    assign in_ready   = !w_full;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign fifo_level = r_level;
    assign tx_count   = r_tx_count;

    // FIFO storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == c_LAST_BIT)) begin
                    w_next_state = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (w_bit_end) begin
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (w_frame_done) begin
                    w_next_state = w_empty ? S_IDLE : S_START;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        STX          = 1'b1;
        r_stx_unused = 1'b0;
        case (r_state)
            S_IDLE:  STX = 1'b1;
            S_START: STX = 1'b0;
            S_DATA:  STX = r_shift[0];
            S_PAR:   STX = w_par_bit;
            S_STOP:  STX = 1'b1;
            default: STX = 1'b1;
        endcase
    end

    // Baud, bit and stop counters plus the shift/parity datapath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_baud     <= c_BAUD_RELOAD;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx_count <= '0;
        end else begin
            if ((r_state == S_IDLE) || w_bit_end) begin
                r_baud <= c_BAUD_RELOAD;
            end else begin
                r_baud <= r_baud - 1'b1;
            end

            if (r_state != S_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (r_state != S_STOP) begin
                r_stop_cnt <= 1'b0;
            end else if (w_bit_end) begin
                r_stop_cnt <= ~r_stop_cnt;
            end

            if (w_pop) begin
                r_shift  <= r_mem[r_rd_ptr];
                r_parity <= 1'b0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_shift  <= {1'b0, r_shift[7:1]};
                r_parity <= r_parity ^ r_shift[0];
            end

            if (w_frame_done) begin
                r_tx_count <= r_tx_count + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_driver.sv
// ============================================================================
// Module   : tb_uart_tx_driver
// Purpose  : Scoreboard bench for uart_tx_driver (8N1, 8E2 and 8O1 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_driver;

    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic        a_valid, a_ready, a_stx, a_busy;
    logic [7:0]  a_data;
    logic [4:0]  a_level;
    logic [31:0] a_count;
    logic        b_valid, b_ready, b_stx, b_busy;
    logic [7:0]  b_data;
    logic [4:0]  b_level;
    logic [31:0] b_count;
    logic        c_valid, c_ready, c_stx, c_busy;
    logic [7:0]  c_data;
    logic [4:0]  c_level;
    logic [31:0] c_count;

    uart_tx_driver #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
        .clock(clock), .reset(reset), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
        .STX(a_stx), .busy(a_busy), .fifo_level(a_level), .tx_count(a_count));

    uart_tx_driver #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
        .clock(clock), .reset(reset), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
        .STX(b_stx), .busy(b_busy), .fifo_level(b_level), .tx_count(b_count));

    uart_tx_driver #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_c (
        .clock(clock), .reset(reset), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
        .STX(c_stx), .busy(c_busy), .fifo_level(c_level), .tx_count(c_count));

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  sb[$];
    int unsigned starts[$];
    bit          mon_en = 1'b0;
    logic [31:0] exp_tx = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte on dut_a; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b, output int waited);
        waited  = 0;
        a_valid = 1'b1;
        a_data  = b;
        while (!a_ready && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        check("send_ready", a_ready, 1);
        sb.push_back(b);
        exp_tx = exp_tx + 32'd1;
        @(negedge clock);
        a_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int i = 0;
        while (a_busy && i < bound) begin
            @(negedge clock);
            i++;
        end
        check(tag, a_busy, 0);
    endtask

    // Frame decoder on dut_a: samples each bit mid-period and scores against the queue.
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (mon_en && !reset && a_stx === 1'b0) begin
                logic [7:0] got;
                starts.push_back(cyc);
                repeat (2) @(negedge clock);
                check("start_bit", a_stx, 0);
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV) @(negedge clock);
                    got[k] = a_stx;
                end
                repeat (DIV) @(negedge clock);
                check("stop_bit", a_stx, 1);
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("frame_data", got, sb.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          w;
        int unsigned n;
        logic        any_low;
        logic        rec_b [0:63];
        logic        rec_c [0:63];
        logic        rec_bb[0:63];
        logic        rec_cb[0:63];
        logic        exp_b [0:11];
        logic        exp_c [0:10];
        logic [7:0]  v;

        a_valid = 1'b0; a_data = '0;
        b_valid = 1'b0; b_data = '0;
        c_valid = 1'b0; c_data = '0;
        repeat (3) @(negedge clock);
        check("rst_stx", a_stx, 1);
        check("rst_ready", a_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_level", a_level, 0);
        check("rst_count", a_count, 0);
        reset = 1'b0;
        @(negedge clock);
        mon_en = 1'b1;

        // Single byte: latency, frame length and busy fall.
        send(8'h55, w);
        n = cyc;
        check("t1_stx_still_idle", a_stx, 1);
        check("t1_level_one", a_level, 1);
        wait_idle(100, "t1_idle");
        check("t1_busy_fall_cycle", cyc, n + 41);
        check("t1_start_cycle", (starts.size() != 0) ? starts[0] : 32'd0, n + 1);
        check("t1_count", a_count, exp_tx);
        any_low = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (a_stx !== 1'b1) any_low = 1'b1;
        end
        check("t1_idle_high", any_low, 0);

        // Back-to-back frames with a simultaneous push and pop.
        starts.delete();
        send(8'h00, w);
        send(8'hFF, w);
        check("t2_level_push_pop", a_level, 1);
        wait_idle(200, "t2_idle");
        check("t2_frames", starts.size(), 2);
        if (starts.size() == 2) check("t2_no_gap", starts[1] - starts[0], 40);
        check("t2_count", a_count, exp_tx);

        // FIFO full while a frame is in flight.
        send(8'h11, w);
        @(negedge clock);
        check("t3_popped", a_level, 0);
        for (int i = 0; i < 16; i++) begin
            v = 8'h20 + 8'(i);
            send(v, w);
            check("t3_no_wait", w, 0);
        end
        check("t3_level_full", a_level, 16);
        check("t3_ready_low", a_ready, 0);
        a_valid = 1'b1;
        a_data  = 8'h3F;
        w = 0;
        while (!a_ready && w < 200) begin
            @(negedge clock);
            w++;
        end
        check("t3_refused", w > 0, 1);
        check("t3_level_at_accept", a_level, 15);
        sb.push_back(8'h3F);
        exp_tx = exp_tx + 32'd1;
        @(negedge clock);
        a_valid = 1'b0;
        check("t3_level_refill", a_level, 16);
        wait_idle(1000, "t3_idle");
        check("t3_sb_empty", sb.size(), 0);
        check("t3_count", a_count, exp_tx);

        // Parity and stop-bit variants, byte 0x07 on both.
        b_valid = 1'b1; b_data = 8'h07;
        c_valid = 1'b1; c_data = 8'h07;
        @(negedge clock);
        b_valid = 1'b0;
        c_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rec_b[i]  = b_stx;
            rec_c[i]  = c_stx;
            rec_bb[i] = b_busy;
            rec_cb[i] = c_busy;
            @(negedge clock);
        end
        v = 8'h07;
        exp_b[0] = 1'b0;
        exp_c[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_b[k+1] = v[k];
            exp_c[k+1] = v[k];
        end
        exp_b[9]  = ^v;
        exp_b[10] = 1'b1;
        exp_b[11] = 1'b1;
        exp_c[9]  = ~(^v);
        exp_c[10] = 1'b1;
        check("t4_b_pre_idle", rec_b[0], 1);
        for (int k = 0; k < 12; k++) begin
            for (int j = 1; j <= DIV; j++) begin
                check($sformatf("t4_b_bit%0d_c%0d", k, j), rec_b[4*k+j], exp_b[k]);
            end
        end
        for (int k = 0; k < 11; k++) begin
            check($sformatf("t4_c_bit%0d", k), rec_c[4*k+2], exp_c[k]);
        end
        check("t4_b_par_value", rec_b[38], 1);
        check("t4_c_par_value", rec_c[38], 0);
        check("t4_b_busy_last", rec_bb[48], 1);
        check("t4_b_busy_fall", rec_bb[49], 0);
        check("t4_c_busy_last", rec_cb[44], 1);
        check("t4_c_busy_fall", rec_cb[45], 0);
        check("t4_c_after_frame", rec_c[46], 1);
        check("t4_b_count", b_count, 1);
        check("t4_c_count", c_count, 1);

        // Asynchronous reset during data bit 3 of 0xA5 with three bytes queued.
        mon_en = 1'b0;
        send(8'hA5, w);
        n = cyc;
        send(8'h01, w);
        send(8'h02, w);
        send(8'h03, w);
        w = 0;
        while (cyc != n + 18 && w < 100) begin
            @(negedge clock);
            w++;
        end
        check("t5_reached_bit3", cyc, n + 18);
        check("t5_pre_stx", a_stx, 0);
        check("t5_pre_level", a_level, 3);
        #2 reset = 1'b1;
        #1;
        check("t5_async_stx", a_stx, 1);
        check("t5_async_level", a_level, 0);
        check("t5_async_busy", a_busy, 0);
        check("t5_async_ready", a_ready, 1);
        check("t5_async_count", a_count, 0);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        exp_tx = '0;
        any_low = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (a_stx !== 1'b1 || a_busy !== 1'b0) any_low = 1'b1;
        end
        check("t5_quiet_after_reset", any_low, 0);
        mon_en = 1'b1;
        send(8'h3C, w);
        wait_idle(100, "t5_idle");
        check("t5_sb_empty", sb.size(), 0);
        check("t5_count", a_count, exp_tx);

        // tx_count wrap.
        @(negedge clock);
        force dut_a.r_tx_count = 32'hFFFF_FFFF;
        @(negedge clock);
        release dut_a.r_tx_count;
        exp_tx = 32'hFFFF_FFFF;
        check("t6_preload", a_count, exp_tx);
        send(8'h5A, w);
        wait_idle(100, "t6_idle");
        check("t6_wrap", a_count, exp_tx);
        check("t6_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
